// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_adder : bit-serial add/subtract, one full-adder cell, LSB first   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_shift_next;

    assign w_accept     = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_run        = (r_state == c_RUN);
    assign w_last       = w_run && (r_cnt == c_LAST);
    assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RUN;
            c_RUN:   if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = start ? c_RUN : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != c_IDLE);
        done = (r_state == c_DONE);
    end

    // Result bits enter at the MSB; the bit shifted out at the bottom is never needed.
    generate
        if (WIDTH == 1) begin : g_single
            assign w_shift_next = w_sum_bit;
        end else begin : g_multi
            logic [WIDTH-2:0] r_shift;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else if (w_run) begin
                    r_shift <= w_shift_next[WIDTH-1:1];
                end
            end
            assign w_shift_next = {w_sum_bit, r_shift};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                sum  <= w_shift_next;
                cout <= w_carry_next;
                ovf  <= r_carry ^ w_carry_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_adder : self-checking bench for serial_adder (WIDTH 8 and 1)   |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic [7:0] sum;
    logic       cout, ovf, busy, done;

    logic       start1, sub1, cin1;
    logic [0:0] a1, b1;
    logic [0:0] sum1;
    logic       cout1, ovf1, busy1, done1;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {ovf, cout, sum} from plain two's-complement arithmetic.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic c, input logic s);
        logic [7:0] yy;
        logic [8:0] t;
        logic       ov;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + 9'(s ? 1'b1 : c);
        ov = (x[7] == yy[7]) && (t[7] != x[7]);
        return {ov, t};
    endfunction

    // Model: an accepted operation delivers its result WIDTH cycles later for one cycle.
    int         m_left;
    logic       m_done, m_cout, m_ovf, p_cout, p_ovf;
    logic [7:0] m_sum, p_sum;
    logic       m_busy;
    assign m_busy = (m_left != 0) || m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_sum  <= p_sum;
                    m_cout <= p_cout;
                    m_ovf  <= p_ovf;
                end
            end else if (start) begin
                m_left <= 8;
                {p_ovf, p_cout, p_sum} <= ref_add(a, b, cin, sub);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            lat++;
            if (busy) bsy++;
        end while (!done && lat < 40);
        check("done_seen", done, 1);
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic icin, input logic isub);
        @(negedge clk);
        start = 1'b1;
        a = ia; b = ib; cin = icin; sub = isub;
    endtask

    initial begin
        int   lat, bsy, s;
        logic seen, ea, eb;

        rst_n = 1'b1;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;

        fork
            forever begin
                @(negedge clk);
                check("model", {busy, done, sum, cout, ovf}, {m_busy, m_done, m_sum, m_cout, m_ovf});
            end
        join_none

        #1 rst_n = 1'b0;
        #2 check("rst_async", {sum, cout, ovf, busy, done}, 0);

        check("pin_sub", ref_add(8'h05, 8'h07, 1'b1, 1'b1), 10'h0FE);
        check("pin_ovf", ref_add(8'h7F, 8'h01, 1'b0, 1'b0), 10'h280);

        // Release reset with start already high: the first edge accepts it.
        @(negedge clk);
        #2 rst_n = 1'b1;
        start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0;
        wait_done(lat, bsy);
        check("add_lat", lat, 9);
        check("add_busy", bsy, 9);
        check("add_res", {ovf, cout, sum}, 10'h04B);
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Back-to-back: start held in DONE.
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bsy);
        check("b2b1_res", {ovf, cout, sum}, 10'h100);
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0;
        wait_done(lat, bsy);
        check("b2b_gap", lat, 9);
        check("b2b2_res", {ovf, cout, sum}, 10'h280);

        issue(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done(lat, bsy);
        check("sub_lat", lat, 9);
        check("sub_res", {ovf, cout, sum}, 10'h0FE);

        // Start pulse mid-RUN must be ignored.
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        repeat (3) @(negedge clk) start = 1'b0;
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b1;
        wait_done(lat, bsy);
        check("ign_lat", lat, 6);
        check("ign_res", {ovf, cout, sum}, 10'h047);
        @(negedge clk);
        check("ign_idle", busy, 0);

        // Reset mid-RUN.
        issue(8'h21, 8'h13, 1'b0, 1'b0);
        repeat (4) @(negedge clk) start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_mid", {sum, cout, ovf, busy, done}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("rst_nodone", seen, 0);
        issue(8'h21, 8'h13, 1'b0, 1'b0);
        wait_done(lat, bsy);
        check("rst_fresh", {ovf, cout, sum}, 10'h034);

        // Randomized traffic; the per-cycle model compare does the checking.
        repeat (600) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=1: exhaustive registered full adder.
        for (int i = 0; i < 8; i++) begin
            ea = 1'(i >> 2);
            eb = 1'(i >> 1);
            @(negedge clk);
            start1 = 1'b1; a1 = ea; b1 = eb; cin1 = 1'(i); sub1 = 1'b0;
            @(negedge clk);
            start1 = 1'b0;
            check("w1_run", {busy1, done1}, 2'b10);
            @(negedge clk);
            s = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
            check("w1_sum", {done1, cout1, sum1}, {1'b1, 2'(s)});
            check("w1_ovf", ovf1, (ea == eb) && (1'(s) != ea));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and result width in bits; legal range 1..64.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, reset, asynchronous and active-low.
REQ-004 Port start SHALL be: input, 1 bit, request a new operation; sampled on the rising edge.
REQ-005 Port sub SHALL be: input, 1 bit, mode select (0 = add, 1 = subtract); sampled with start.
REQ-006 Port cin SHALL be: input, 1 bit, carry-in for add mode; sampled with start; ignored when sub=1.
REQ-007 Ports a and b SHALL be: inputs, WIDTH bits each, operands; sampled with start.
REQ-008 Port sum SHALL be: output, WIDTH bits, registered result.
REQ-009 Port cout SHALL be: output, 1 bit, registered carry out of the MSB.
REQ-010 Port ovf SHALL be: output, 1 bit, registered signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.
REQ-011 Port busy SHALL be: output, 1 bit, high while an operation is in progress or completing.
REQ-012 Port done SHALL be: output, 1 bit, single-cycle pulse marking that sum, cout and ovf are valid.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE, plus an internal bit counter.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL accept an operation and move to RUN.
REQ-015 On acceptance, the block SHALL capture a, capture b (b inverted when sub=1), clear the counter, and load the carry flip-flop with cin (add) or 1 (subtract).
REQ-016 In RUN, each edge SHALL process exactly one bit, LSB first, using one full-adder cell.
REQ-017 For each processed bit i, the result bit SHALL be a[i]^b'[i]^c, and the carry SHALL update to the majority of the three.
REQ-018 The processed result bit SHALL be shifted into an internal result shift register from the MSB end.
REQ-019 At the edge that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-020 At that same edge, sum, cout and ovf SHALL be updated with the final result.
REQ-021 done SHALL be 1 only while in DONE, which is exactly one cycle.
REQ-022 done SHALL first be high WIDTH cycles after the accepting edge.
REQ-023 From DONE, the FSM SHALL go to IDLE if start=0, or to RUN if start=1, giving a back-to-back throughput of one operation per WIDTH+1 cycles.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 start SHALL be ignored while in RUN, and operands SHALL NOT be re-sampled in that state.
REQ-026 sum, cout and ovf SHALL hold their values between DONE updates and SHALL NOT change during RUN.
REQ-027 With WIDTH=1, the block SHALL behave as a registered full adder, with done one cycle after acceptance.
REQ-028 In subtract mode, the result SHALL be a-b modulo 2^WIDTH, with cout=1 meaning no borrow.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE, and sum, cout, ovf, busy and done SHALL be 0, independent of clk.
REQ-030 Assertion of rst_n mid-RUN SHALL discard the operation, and no done SHALL be produced for it.
REQ-031 The first edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-032 The bench SHALL run WIDTH=8, start with a=0x3C, b=0x0F, cin=0, sub=0, and require done 8 cycles later with sum=0x4B, cout=0, ovf=0, and busy high for 9 cycles.
REQ-033 The bench SHALL run WIDTH=8 with a=0xFF, b=0x01, then a=0x7F, b=0x01, issued back-to-back (start held in DONE), and require sum=0x00, cout=1, ovf=0, then sum=0x80, cout=0, ovf=1, with the dones 9 cycles apart.
REQ-034 The bench SHALL run WIDTH=8, sub=1, a=0x05, b=0x07, cin=1 (ignored), and require sum=0xFE, cout=0, ovf=0.
REQ-035 The bench SHALL pulse start with new operands 3 cycles into RUN and require that the result reflects the original operands only.
REQ-036 The bench SHALL assert rst_n low 4 cycles into RUN and require that all outputs read 0 immediately, no done is produced, and a fresh start afterwards gives the correct result.
REQ-037 The bench SHALL run WIDTH=1 exhaustively over all 8 combinations of a, b and cin, and require sum and cout to match the full-adder truth table.
